// File: rtl/cp0_reg.sv
`default_nettype none
// ============================================================================
// Module   : cp0_reg
// Brief    : MIPS CP0 register file with exception/ERET commit, MTC0/MFC0
//            access and the Count/Compare timer interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_reg #(
    parameter logic [31:0] PRID_VAL = 32'h0000_4220
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [4:0] c_REG_BADVADDR = 5'd8;
    localparam logic [4:0] c_REG_COUNT    = 5'd9;
    localparam logic [4:0] c_REG_COMPARE  = 5'd11;
    localparam logic [4:0] c_REG_STATUS   = 5'd12;
    localparam logic [4:0] c_REG_CAUSE    = 5'd13;
    localparam logic [4:0] c_REG_EPC      = 5'd14;
    localparam logic [4:0] c_REG_PRID     = 5'd15;

    localparam logic [31:0] c_EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] c_EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] c_EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] c_EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] c_EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] c_EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] c_EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] c_EXC_ERET = 32'h0000_000e;

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_tick;
    logic        r_timer_int;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic        r_cause_ti;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exccode;

    logic        w_exc;
    logic        w_eret;
    logic        w_addr_exc;
    logic [4:0]  w_exc_code;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;

    // Unknown nonzero codes fall through to "no exception".
    always_comb begin
        w_exc      = 1'b1;
        w_exc_code = 5'd0;
        unique case (excepttype_i)
            c_EXC_INT:  w_exc_code = 5'd0;
            c_EXC_ADEL: w_exc_code = 5'd4;
            c_EXC_ADES: w_exc_code = 5'd5;
            c_EXC_SYS:  w_exc_code = 5'd8;
            c_EXC_BP:   w_exc_code = 5'd9;
            c_EXC_RI:   w_exc_code = 5'd10;
            c_EXC_OV:   w_exc_code = 5'd12;
            default:    w_exc      = 1'b0;
        endcase
    end

    assign w_eret       = (excepttype_i == c_EXC_ERET);
    assign w_addr_exc   = (excepttype_i == c_EXC_ADEL) || (excepttype_i == c_EXC_ADES);
    assign w_wr_count   = we_i && (waddr_i == c_REG_COUNT);
    assign w_wr_compare = we_i && (waddr_i == c_REG_COMPARE);
    assign w_wr_status  = we_i && (waddr_i == c_REG_STATUS);
    assign w_wr_cause   = we_i && (waddr_i == c_REG_CAUSE);
    assign w_wr_epc     = we_i && (waddr_i == c_REG_EPC);

    // Count advances on every other cycle; a software load restarts the phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= 32'd0;
            r_tick  <= 1'b0;
        end else if (w_wr_count) begin
            r_count <= data_i;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            if (r_tick)
                r_count <= r_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_compare   <= 32'd0;
            r_timer_int <= 1'b0;
        end else if (w_wr_compare) begin
            r_compare   <= data_i;
            r_timer_int <= 1'b0;
        end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
            r_timer_int <= 1'b1;
        end
    end

    // Exception/ERET assignments come last so they override MTC0 on EXL.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_status_im  <= 8'd0;
            r_status_exl <= 1'b0;
            r_status_ie  <= 1'b0;
        end else begin
            if (w_wr_status) begin
                r_status_im  <= data_i[15:8];
                r_status_exl <= data_i[1];
                r_status_ie  <= data_i[0];
            end
            if (w_exc)
                r_status_exl <= 1'b1;
            else if (w_eret)
                r_status_exl <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cause_bd      <= 1'b0;
            r_cause_ti      <= 1'b0;
            r_cause_ip_hw   <= 6'd0;
            r_cause_ip_sw   <= 2'd0;
            r_cause_exccode <= 5'd0;
        end else begin
            r_cause_ip_hw <= {int_i[5] | r_timer_int, int_i[4:0]};
            r_cause_ti    <= r_timer_int;
            if (w_wr_cause)
                r_cause_ip_sw <= data_i[9:8];
            if (w_exc) begin
                r_cause_exccode <= w_exc_code;
                if (!r_status_exl)
                    r_cause_bd <= is_in_delayslot_i;
            end
        end
    end

    // A nested exception (EXL already set) keeps the original return PC.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_epc <= 32'd0;
        end else if (w_exc && !r_status_exl) begin
            r_epc <= is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;
        end else if (w_wr_epc) begin
            r_epc <= data_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_badvaddr <= 32'd0;
        else if (w_addr_exc)
            r_badvaddr <= bad_addr_i;
    end

    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign status_o    = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
    assign cause_o     = {r_cause_bd, r_cause_ti, 14'd0, r_cause_ip_hw, r_cause_ip_sw,
                          1'b0, r_cause_exccode, 2'd0};
    assign epc_o       = r_epc;
    assign badvaddr_o  = r_badvaddr;
    assign timer_int_o = r_timer_int;

    always_comb begin
        data_o = 32'd0;
        unique case (raddr_i)
            c_REG_BADVADDR: data_o = r_badvaddr;
            c_REG_COUNT:    data_o = r_count;
            c_REG_COMPARE:  data_o = r_compare;
            c_REG_STATUS:   data_o = status_o;
            c_REG_CAUSE:    data_o = cause_o;
            c_REG_EPC:      data_o = r_epc;
            c_REG_PRID:     data_o = PRID_VAL;
            default:        data_o = 32'd0;
        endcase
    end

endmodule
`default_nettype wire
